leitor_gamepad_genesis: RTL and testbench

Polls a Sega Genesis/Mega Drive 3- or 6-button controller through its DB9 port. It drives the select line, samples the six active-low data pins, and decodes the 12 button states. The result is published as the 12-bit active-high Entradas vector consumed by the input-timing/sprite-position stage. It also flags controller presence and 6-button capability.

---
 rtl/leitor_gamepad_genesis.sv | 149 ++++++++++++++
 tb/tb_leitor_gamepad_genesis.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/leitor_gamepad_genesis.sv
// Polls a Sega Genesis 3/6-button pad through its DB9 port and publishes
// the 12 decoded buttons plus presence and 6-button flags once per poll.
module leitor_gamepad_genesis #(
    parameter int PHASE_CYCLES = 500,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic        Clock50,
    input  logic        Reset,
    input  logic [5:0]  PadDados,
    output logic        PadSelect,
    output logic [11:0] Saidas,
    output logic        Conectado,
    output logic        SeisBotoes,
    output logic        NovaLeitura
);
    localparam int TW = $clog2(POLL_CYCLES);
    localparam int PW = $clog2(PHASE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);

    typedef enum logic {OCIOSO, LEITURA} estadoT;

    estadoT        state, stateNext;
    logic [2:0]    phase, phaseNext;
    logic [PW-1:0] phaseCnt, phaseCntNext;
    logic [TW-1:0] timer;
    logic [5:0]    sync1, sync2;
    logic [5:0]    pressed;
    logic [11:0]   shadow;
    logic          present, six;
    logic          selectNext, commit, phaseEnd;

    assign pressed = ~sync2;

    // Synchronizers idle at the pull-up level so a reset looks like "nothing pressed".
    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= PadDados;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset)
            timer <= '0;
        else if (timer == TIMER_LAST)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    always_comb begin
        stateNext    = state;
        phaseNext    = phase;
        phaseCntNext = phaseCnt;
        commit       = 1'b0;
        phaseEnd     = 1'b0;
        case (state)
            OCIOSO: begin
                if (timer == TIMER_LAST) begin
                    stateNext    = LEITURA;
                    phaseNext    = 3'd0;
                    phaseCntNext = '0;
                end
            end
            LEITURA: begin
                if (phaseCnt == PHASE_LAST) begin
                    phaseEnd     = 1'b1;
                    phaseCntNext = '0;
                    if (phase == 3'd7) begin
                        stateNext = OCIOSO;
                        commit    = 1'b1;
                    end else begin
                        phaseNext = phase + 3'd1;
                    end
                end else begin
                    phaseCntNext = phaseCnt + 1'b1;
                end
            end
            default: stateNext = OCIOSO;
        endcase
        // Select is high while idle and in even phases, so it toggles with the phase index.
        selectNext = (stateNext == OCIOSO) || !phaseNext[0];
    end

    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            state     <= OCIOSO;
            phase     <= 3'd0;
            phaseCnt  <= '0;
            PadSelect <= 1'b1;
        end else begin
            state     <= stateNext;
            phase     <= phaseNext;
            phaseCnt  <= phaseCntNext;
            PadSelect <= selectNext;
        end
    end

    // Shadow capture on the last cycle of each phase, after the pad has settled.
    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            shadow  <= '0;
            present <= 1'b0;
            six     <= 1'b0;
        end else if (phaseEnd) begin
            case (phase)
                3'd0: begin
                    shadow[3:0] <= pressed[3:0];
                    shadow[6:5] <= pressed[5:4];
                end
                3'd1: begin
                    shadow[4]  <= pressed[4];
                    shadow[10] <= pressed[5];
                    present    <= pressed[2] & pressed[3];
                end
                3'd5: six <= &pressed[3:0];
                3'd6: begin
                    shadow[9]  <= six & pressed[0];
                    shadow[8]  <= six & pressed[1];
                    shadow[7]  <= six & pressed[2];
                    shadow[11] <= six & pressed[3];
                end
                default: ;
            endcase
        end
    end

    // An absent pad reads all-high through pull-ups, so outputs are gated by presence.
    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            Saidas      <= '0;
            Conectado   <= 1'b0;
            SeisBotoes  <= 1'b0;
            NovaLeitura <= 1'b0;
        end else begin
            NovaLeitura <= commit;
            if (commit) begin
                Saidas     <= present ? shadow : 12'h000;
                Conectado  <= present;
                SeisBotoes <= present & six;
            end
        end
    end

endmodule

// File: tb/tb_leitor_gamepad_genesis.sv
// Bench for leitor_gamepad_genesis: a behavioural Genesis pad answers the select
// line, and expected outputs come from the pressed-button set and pad type.
module tb_leitor_gamepad_genesis;
    localparam int PHASE = 4;
    localparam int POLL  = 64;
    localparam int READ  = 8 * PHASE;

    logic        Clock50 = 1'b0;
    logic        Reset;
    logic [5:0]  PadDados;
    logic        PadSelect;
    logic [11:0] Saidas;
    logic        Conectado;
    logic        SeisBotoes;
    logic        NovaLeitura;

    logic [11:0] padBtn     = 12'h000;
    bit          padSix     = 1'b1;
    bit          padPresent = 1'b1;
    int          padIdx     = 0;
    int          cyc        = 0;
    int          checks     = 0;
    int          passed     = 0;
    int          failed     = 0;

    always #5 Clock50 = ~Clock50;

    leitor_gamepad_genesis #(.PHASE_CYCLES(PHASE), .POLL_CYCLES(POLL)) dut (
        .Clock50    (Clock50),
        .Reset      (Reset),
        .PadDados   (PadDados),
        .PadSelect  (PadSelect),
        .Saidas     (Saidas),
        .Conectado  (Conectado),
        .SeisBotoes (SeisBotoes),
        .NovaLeitura(NovaLeitura)
    );

    // The pad counts select transitions; the eighth one returns it to its first state.
    always @(posedge PadSelect or negedge PadSelect or posedge Reset) begin
        if (Reset || padIdx >= 7)
            padIdx = 0;
        else
            padIdx = padIdx + 1;
    end

    function automatic logic [5:0] padPins(int idx, logic [11:0] b, bit six, bit present);
        logic [5:0] p;
        if (!present) return 6'h3F;
        if (six && idx == 5)      p = {b[10], b[4], 4'b1111};
        else if (six && idx == 6) p = {b[6], b[5], b[11], b[7], b[8], b[9]};
        else if (six && idx == 7) p = {b[10], b[4], 4'b0000};
        else if (idx % 2 == 0)    p = {b[6], b[5], b[3], b[2], b[1], b[0]};
        else                      p = {b[10], b[4], 2'b11, b[1], b[0]};
        return ~p;
    endfunction

    assign PadDados = padPins(padIdx, padBtn, padSix, padPresent);

    function automatic logic [11:0] refSaidas(logic [11:0] btn, bit six, bit present);
        if (!present) return 12'h000;
        if (six) return btn;
        return btn & 12'h47F;
    endfunction

    function automatic logic expSelect(int k);
        if (k >= POLL && k < POLL + READ) return ((k - POLL) / PHASE) % 2 == 0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge Clock50);
        #1;
        cyc++;
    endtask

    task automatic stepTo(int target);
        while (cyc < target) tick();
    endtask

    task automatic checkOutput(string tag, logic [11:0] observed, logic [11:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(logic [11:0] btn, bit six, bit present);
        padBtn     = btn;
        padSix     = six;
        padPresent = present;
    endtask

    // Expects to be called on the commit cycle; also confirms the pulse is one cycle wide.
    task automatic checkCommit(string tag, logic [11:0] btn, bit six, bit present);
        checkOutput({tag, "_saidas"}, Saidas, refSaidas(btn, six, present));
        checkOutput({tag, "_conectado"}, 12'(Conectado), 12'(present));
        checkOutput({tag, "_seis"}, 12'(SeisBotoes), 12'(present & six));
        checkOutput({tag, "_nova"}, 12'(NovaLeitura), 12'd1);
        tick();
        checkOutput({tag, "_nova_off"}, 12'(NovaLeitura), 12'd0);
        checkOutput({tag, "_hold"}, Saidas, refSaidas(btn, six, present));
    endtask

    // Walks the first poll after a reset release cycle by cycle.
    task automatic checkFirstPoll(string tag, logic [11:0] btn, bit six, bit present);
        for (int k = 1; k <= POLL + READ; k++) begin
            tick();
            checkOutput({tag, "_select"}, 12'(PadSelect), 12'(expSelect(k)));
            if (k < POLL + READ) begin
                checkOutput({tag, "_nova_idle"}, 12'(NovaLeitura), 12'd0);
                checkOutput({tag, "_saidas_idle"}, Saidas, 12'h000);
            end
        end
        checkCommit(tag, btn, six, present);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] rb;
        bit          rs, rp;
        int          commitAt;

        Reset = 1'b1;
        applyStimulus(12'h811, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("reset_select", 12'(PadSelect), 12'd1);
        checkOutput("reset_saidas", Saidas, 12'h000);
        checkOutput("reset_conectado", 12'(Conectado), 12'd0);
        checkOutput("reset_seis", 12'(SeisBotoes), 12'd0);
        checkOutput("reset_nova", 12'(NovaLeitura), 12'd0);
        Reset = 1'b0;
        cyc = 0;

        checkFirstPoll("six_up_a_mode", 12'h811, 1'b1, 1'b1);

        applyStimulus(12'h448, 1'b0, 1'b1);
        stepTo(2 * POLL + READ);
        checkCommit("three_start_c_right", 12'h448, 1'b0, 1'b1);

        applyStimulus(12'h3FF, 1'b1, 1'b0);
        stepTo(3 * POLL + READ);
        checkCommit("absent", 12'h3FF, 1'b1, 1'b0);

        applyStimulus(12'h925, 1'b1, 1'b1);
        stepTo(4 * POLL + 3 * PHASE + 2);
        applyStimulus(12'h95A, 1'b1, 1'b1);
        stepTo(4 * POLL + READ);
        checkCommit("midpoll_phase3_old", 12'h925, 1'b1, 1'b1);
        stepTo(5 * POLL + 7 * PHASE + 1);
        applyStimulus(12'h925, 1'b1, 1'b1);
        stepTo(5 * POLL + READ);
        checkCommit("midpoll_phase3_new", 12'h95A, 1'b1, 1'b1);
        stepTo(6 * POLL + READ);
        checkCommit("midpoll_phase7_new", 12'h925, 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            rb = 12'($urandom);
            rs = 1'($urandom_range(0, 1));
            rp = ($urandom_range(0, 4) != 0);
            if (!rs && rb[0]) rb[1] = 1'b0;
            applyStimulus(rb, rs, rp);
            commitAt = (7 + i) * POLL + READ;
            stepTo(commitAt);
            checkCommit($sformatf("random%0d", i), rb, rs, rp);
        end

        applyStimulus(12'hFFF, 1'b1, 1'b1);
        stepTo(13 * POLL + READ);
        checkCommit("all_pressed", 12'hFFF, 1'b1, 1'b1);

        stepTo(14 * POLL + 3 * PHASE + 1);
        checkOutput("pre_abort_select", 12'(PadSelect), 12'd0);
        Reset = 1'b1;
        #1;
        checkOutput("abort_select", 12'(PadSelect), 12'd1);
        checkOutput("abort_saidas", Saidas, 12'h000);
        checkOutput("abort_conectado", 12'(Conectado), 12'd0);
        checkOutput("abort_seis", 12'(SeisBotoes), 12'd0);
        checkOutput("abort_nova", 12'(NovaLeitura), 12'd0);
        @(posedge Clock50);
        @(posedge Clock50);
        #1;
        Reset = 1'b0;
        cyc = 0;
        checkFirstPoll("after_abort", 12'hFFF, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
